// File: rtl/uart_autobaud_if.sv
// Control/status bundle between the register block, the RX line and the
// baud-rate detector.
interface uart_autobaud_if;
  logic        start;
  logic        abort;
  logic        rx;
  logic [15:0] cfg_div;
  logic        cfg_update;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  modport master (
    output start, abort, rx,
    input  cfg_div, cfg_update, busy, done, error, err_code
  );

  modport slave (
    input  start, abort, rx,
    output cfg_div, cfg_update, busy, done, error, err_code
  );
endinterface

// File: rtl/uart_autobaud.sv
// Automatic baud-rate detector: times a 0x55 sync character on rx and
// programs the baud generator divider as round(T/8) - 1.
module uart_autobaud #(
  parameter logic [15:0] DEFAULT_DIV    = 16'd867,
  parameter logic [15:0] MIN_DIV        = 16'd16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int unsigned TOL_SHIFT      = 2,
  parameter int unsigned CNT_W          = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_autobaud_if.slave bus
);

  localparam int unsigned QW = CNT_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_FALL, MEASURE, CALC} state_t;

  state_t             state, state_d;
  logic               rx_q;
  logic               fall;
  logic [31:0]        tmo, tmo_d;
  logic [CNT_W-1:0]   total, total_d;
  logic [CNT_W-1:0]   ivl, ivl_d;
  logic [CNT_W-1:0]   i1, i1_d;
  logic [CNT_W-1:0]   ik, diff;
  logic [2:0]         edge_cnt, edge_cnt_d;
  logic [CNT_W:0]     sum;
  logic [QW-1:0]      q;
  logic               fail;
  logic [1:0]         fail_code;

  logic [15:0]        cfg_div_r, cfg_div_d;
  logic               cfg_update_r, cfg_update_d;
  logic               busy_r, busy_d;
  logic               done_r, done_d;
  logic               error_r, error_d;
  logic [1:0]         err_code_r, err_code_d;

  assign fall = rx_q & ~bus.rx;
  assign ik   = CNT_W'(ivl + 1'b1);
  assign diff = (ik > i1) ? CNT_W'(ik - i1) : CNT_W'(i1 - ik);
  assign sum  = (CNT_W+1)'(total) + (CNT_W+1)'(4);
  assign q    = QW'(sum >> 3);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_q         <= 1'b1;
      tmo          <= '0;
      total        <= '0;
      ivl          <= '0;
      i1           <= '0;
      edge_cnt     <= '0;
      cfg_div_r    <= DEFAULT_DIV;
      cfg_update_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      err_code_r   <= 2'd0;
    end else begin
      state        <= state_d;
      rx_q         <= bus.rx;
      tmo          <= tmo_d;
      total        <= total_d;
      ivl          <= ivl_d;
      i1           <= i1_d;
      edge_cnt     <= edge_cnt_d;
      cfg_div_r    <= cfg_div_d;
      cfg_update_r <= cfg_update_d;
      busy_r       <= busy_d;
      done_r       <= done_d;
      error_r      <= error_d;
      err_code_r   <= err_code_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    tmo_d        = tmo;
    total_d      = total;
    ivl_d        = ivl;
    i1_d         = i1;
    edge_cnt_d   = edge_cnt;
    cfg_div_d    = cfg_div_r;
    err_code_d   = err_code_r;
    cfg_update_d = 1'b0;
    done_d       = 1'b0;
    error_d      = 1'b0;
    fail         = 1'b0;
    fail_code    = 2'd0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = ARM;
          tmo_d   = '0;
        end
      end
      ARM, WAIT_FALL: begin
        if ((TIMEOUT_CYCLES != 32'd0) && (tmo == TIMEOUT_CYCLES)) begin
          fail      = 1'b1;
          fail_code = 2'd0;
        end else begin
          tmo_d = tmo + 32'd1;
          if (state == ARM) begin
            if (bus.rx) state_d = WAIT_FALL;
          end else if (fall) begin
            state_d    = MEASURE;
            total_d    = '0;
            ivl_d      = '0;
            edge_cnt_d = 3'd1;
          end
        end
      end
      MEASURE: begin
        if ((total == CNT_MAX) || (ivl == CNT_MAX)) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end else begin
          total_d = CNT_W'(total + 1'b1);
          ivl_d   = CNT_W'(ivl + 1'b1);
          if (fall) begin
            edge_cnt_d = edge_cnt + 3'd1;
            ivl_d      = '0;
            if (edge_cnt == 3'd1) begin
              i1_d = ik;
            end else if (diff > (i1 >> TOL_SHIFT)) begin
              fail      = 1'b1;
              fail_code = 2'd2;
            end else if (edge_cnt == 3'd4) begin
              state_d = CALC;
            end
          end
        end
      end
      CALC: begin
        if (32'(q) > 32'd65536) begin
          fail      = 1'b1;
          fail_code = 2'd1;
        end else if (32'(q) < (32'(MIN_DIV) + 32'd1)) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end else begin
          cfg_div_d    = 16'(q - 1'b1);
          cfg_update_d = 1'b1;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      state_d    = IDLE;
      error_d    = 1'b1;
      err_code_d = fail_code;
    end

    // Abort wins over start, completion and failure alike
    if (bus.abort) begin
      state_d      = IDLE;
      cfg_div_d    = cfg_div_r;
      err_code_d   = err_code_r;
      cfg_update_d = 1'b0;
      done_d       = 1'b0;
      error_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.cfg_div    = cfg_div_r;
  assign bus.cfg_update = cfg_update_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;
  assign bus.err_code   = err_code_r;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: sync characters at several rates plus
// jitter, timeout, overflow, abort and reset scenarios.
module tb_uart_autobaud;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_errors = 0;

  int done_cnt = 0, done_cyc = -1;
  int upd_cnt = 0, upd_cyc = -1;
  int err_cnt = 0, err_cyc = -1;
  logic busy_at_done = 1'b1;

  uart_autobaud_if bus ();

  uart_autobaud #(
    .DEFAULT_DIV    (16'd867),
    .MIN_DIV        (16'd16),
    .TIMEOUT_CYCLES (32'd1000),
    .TOL_SHIFT      (2),
    .CNT_W          (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
    end
    if (bus.cfg_update) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (bus.error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  // 0x55 framed LSB-first; f5 is the cycle in which the fifth fall is seen
  task automatic send_sync(input int p, output int f5);
    logic [9:0] frame;
    frame = {1'b1, 8'h55, 1'b0};
    f5 = -1;
    for (int b = 0; b < 10; b++) begin
      bus.rx = frame[b];
      if (b == 8) f5 = cyc;
      repeat (p) tick();
    end
    bus.rx = 1'b1;
  endtask

  task automatic wait_error(input int limit, input string tag);
    int base;
    int n;
    base = err_cnt;
    n = 0;
    while (err_cnt == base && n < limit) begin
      tick();
      n++;
    end
    if (err_cnt == base) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no error pulse within %0d cycles", tag, limit);
    end
  endtask

  task automatic good_sync(input int p, input logic [15:0] exp_div, input string tag);
    int f5;
    int d0;
    d0 = done_cnt;
    do_start();
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    send_sync(p, f5);
    check({tag, "_div"}, 32'(bus.cfg_div), 32'(exp_div));
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(f5 + 2));
    check({tag, "_upd_cyc"}, 32'(upd_cyc), 32'(f5 + 2));
    check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
  endtask

  initial begin
    int f5, k, a, s, e0, d0, u0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rx    = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_div", 32'(bus.cfg_div), 32'd867);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    check("rst_update", 32'(bus.cfg_update), 32'd0);
    check("rst_code", 32'(bus.err_code), 32'd0);

    // T=800 -> q=100 -> 99
    good_sync(100, 16'd99, "sync100");
    // T=136 -> q=17 -> 16 (exactly MIN_DIV)
    good_sync(17, 16'd16, "sync17");

    // T=120 -> q=15 -> 14 < 16: too fast
    e0 = err_cnt; u0 = upd_cnt;
    do_start();
    send_sync(15, f5);
    check("fast_err_cyc", 32'(err_cyc), 32'(f5 + 2));
    check("fast_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("fast_code", 32'(bus.err_code), 32'd3);
    check("fast_div", 32'(bus.cfg_div), 32'd16);
    check("fast_no_upd", 32'(upd_cnt - u0), 32'd0);

    // Falls at k, k+200, k+460: I2=260 vs limit 200+50
    e0 = err_cnt;
    do_start();
    bus.rx = 1'b0; k = cyc;
    repeat (100) tick(); bus.rx = 1'b1;
    repeat (100) tick(); bus.rx = 1'b0;
    repeat (100) tick(); bus.rx = 1'b1;
    repeat (160) tick(); bus.rx = 1'b0;
    repeat (5) tick(); bus.rx = 1'b1;
    check("jit_err_cyc", 32'(err_cyc), 32'(k + 461));
    check("jit_code", 32'(bus.err_code), 32'd2);
    check("jit_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("jit_div", 32'(bus.cfg_div), 32'd16);
    repeat (5) tick();

    // Timeout: tmo hits 1000 in cycle s+1001, error visible s+1002
    s = cyc;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_error(1100, "timeout_wait");
    check("tmo_err_cyc", 32'(err_cyc), 32'(s + 1002));
    check("tmo_code", 32'(bus.err_code), 32'd0);
    tick();
    check("tmo_busy", 32'(bus.busy), 32'd0);

    // Overflow: total reaches 4095 in cycle k+4096, error at k+4097
    do_start();
    bus.rx = 1'b0; k = cyc;
    wait_error(4200, "ovf_wait");
    check("ovf_err_cyc", 32'(err_cyc), 32'(k + 4097));
    check("ovf_code", 32'(bus.err_code), 32'd1);
    bus.rx = 1'b1;
    repeat (3) tick();

    // Abort after third fall
    e0 = err_cnt; d0 = done_cnt; u0 = upd_cnt;
    do_start();
    bus.rx = 1'b0; repeat (100) tick(); bus.rx = 1'b1; repeat (100) tick();
    bus.rx = 1'b0; repeat (100) tick(); bus.rx = 1'b1; repeat (100) tick();
    bus.rx = 1'b0; repeat (10) tick();
    a = cyc;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    check("abort_busy_after", 32'(bus.busy), 32'd0);
    repeat (90) tick(); bus.rx = 1'b1; repeat (100) tick();
    bus.rx = 1'b0; repeat (100) tick(); bus.rx = 1'b1; repeat (100) tick();
    bus.rx = 1'b0; repeat (100) tick(); bus.rx = 1'b1; repeat (100) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_err", 32'(err_cnt - e0), 32'd0);
    check("abort_no_upd", 32'(upd_cnt - u0), 32'd0);
    check("abort_div", 32'(bus.cfg_div), 32'd16);
    check("abort_code_held", 32'(bus.err_code), 32'd1);
    if (a < 0) check("abort_cyc", 32'(a), 32'd0);

    good_sync(100, 16'd99, "resync100");

    // start with abort in IDLE stays idle
    bus.start = 1'b1; bus.abort = 1'b1; tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    check("start_abort_busy2", 32'(bus.busy), 32'd0);

    // Reset mid-measurement
    do_start();
    bus.rx = 1'b0; repeat (50) tick(); bus.rx = 1'b1; repeat (50) tick();
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_rst_div", 32'(bus.cfg_div), 32'd867);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_code", 32'(bus.err_code), 32'd0);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
